rtc_seg_scan_mux: RTL and testbench

Parametrised, time-multiplexed 7-segment scan driver for the RTC/stopwatch display path. It sits between the per-digit segment encoders and the board's shared segment/anode pins, and drives one digit at a time. Compared with the fixed six-digit scanner it adds:
- configurable digit count and slot length;
- an anti-ghosting blank window at the start of each slot;
- 16-level PWM brightness;
- a per-digit blank mask;
- double-buffered, tear-free frame updates through a load strobe.

---
 rtl/rtc_seg_scan_mux.sv | 162 ++++++++++++++++
 tb/tb_rtc_seg_scan_mux.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_seg_scan_mux.sv
// rtc_seg_scan_mux
//   Time-multiplexed 7-segment scan driver for the RTC/stopwatch display.
//   Drives one digit per slot. Each slot starts with an all-off blank window
//   to suppress ghosting. The rest of the slot is gated by a 16-level PWM
//   and a per-digit blank mask. New frame data is double-buffered: i_load
//   fills a shadow register, which is committed only at frame end, so a
//   frame is never torn.
//
// Ports
//   i_sys_clk      system clock
//   i_reset_n      synchronous, active-low reset
//   i_enable       scan enable; low forces counters to 0 and outputs off
//   i_seg_data     segment codes, digit k at [8k+7:8k]
//   i_blank_mask   bit k = 1 blanks digit k
//   i_load         one-cycle strobe capturing i_seg_data / i_blank_mask
//   i_bright       PWM brightness, 0 = 1/16 duty, 15 = full
//   o_segments     segment code for the current digit (registered)
//   o_digits       one-hot digit enables, polarity per DIGIT_ACTIVE_LOW
//   o_frame_start  pulse on the output cycle of digit 0, slot cycle 0
//   o_update_done  pulse on the first output cycle of a newly committed frame

module rtc_seg_scan_mux #(
    parameter int unsigned NUM_DIGITS       = 6,
    parameter int unsigned CYCLES_PER_DIGIT = 100000,
    parameter int unsigned BLANK_CYCLES     = 1000,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
    parameter logic [7:0]  SEG_OFF          = 8'hFF
) (
    input  logic                    i_sys_clk,
    input  logic                    i_reset_n,
    input  logic                    i_enable,
    input  logic [8*NUM_DIGITS-1:0] i_seg_data,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    input  logic                    i_load,
    input  logic [3:0]              i_bright,
    output logic [7:0]              o_segments,
    output logic [NUM_DIGITS-1:0]   o_digits,
    output logic                    o_frame_start,
    output logic                    o_update_done
);

    localparam int unsigned CW = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST    = CW'(CYCLES_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_START = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIGIT_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    pwm_q, pwm_d;

    logic [NUM_DIGITS-1:0][7:0] shadow_seg_q, shadow_seg_d;
    logic [NUM_DIGITS-1:0]      shadow_mask_q, shadow_mask_d;
    logic                       pending_q, pending_d;
    logic [NUM_DIGITS-1:0][7:0] active_seg_q, active_seg_d;
    logic [NUM_DIGITS-1:0]      active_mask_q, active_mask_d;
    logic                       commit_q, commit_d;

    logic [7:0]            segments_q, segments_d;
    logic [NUM_DIGITS-1:0] digits_q, digits_d;
    logic                  frame_start_q, frame_start_d;
    logic                  update_done_q, update_done_d;

    logic                  frame_end;
    logic                  lit;
    logic [NUM_DIGITS-1:0] dig_one_hot;

    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        pwm_d         = pwm_q;
        shadow_seg_d  = shadow_seg_q;
        shadow_mask_d = shadow_mask_q;
        pending_d     = pending_q;
        active_seg_d  = active_seg_q;
        active_mask_d = active_mask_q;
        commit_d      = 1'b0;

        frame_end = i_enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

        if (!i_enable) begin
            cnt_d = '0;
            idx_d = '0;
            pwm_d = '0;
        end else begin
            pwm_d = pwm_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (i_load) begin
            shadow_seg_d  = i_seg_data;
            shadow_mask_d = i_blank_mask;
            pending_d     = 1'b1;
        end

        // A load on the frame-end cycle bypasses the shadow and commits directly.
        if (frame_end && (pending_q || i_load)) begin
            active_seg_d  = i_load ? i_seg_data   : shadow_seg_q;
            active_mask_d = i_load ? i_blank_mask : shadow_mask_q;
            pending_d     = 1'b0;
            commit_d      = 1'b1;
        end

        // Display decisions use the pre-commit active register, so the
        // frame-end cycle still shows the old frame.
        lit = i_enable && (cnt_q >= BLANK_START) && (pwm_q <= i_bright)
              && !active_mask_q[idx_q];
        dig_one_hot = NUM_DIGITS'(1) << idx_q;

        segments_d    = lit ? active_seg_q[idx_q] : SEG_OFF;
        digits_d      = lit ? (DIGIT_ACTIVE_LOW ? ~dig_one_hot : dig_one_hot) : DIG_OFF;
        frame_start_d = i_enable && (cnt_q == '0) && (idx_q == '0);
        // Delayed by one clock so the pulse lines up with the new frame's first output.
        update_done_d = commit_q;
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            shadow_seg_q  <= {NUM_DIGITS{SEG_OFF}};
            shadow_mask_q <= '0;
            pending_q     <= 1'b0;
            active_seg_q  <= {NUM_DIGITS{SEG_OFF}};
            active_mask_q <= '0;
            commit_q      <= 1'b0;
            segments_q    <= SEG_OFF;
            digits_q      <= DIG_OFF;
            frame_start_q <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            shadow_seg_q  <= shadow_seg_d;
            shadow_mask_q <= shadow_mask_d;
            pending_q     <= pending_d;
            active_seg_q  <= active_seg_d;
            active_mask_q <= active_mask_d;
            commit_q      <= commit_d;
            segments_q    <= segments_d;
            digits_q      <= digits_d;
            frame_start_q <= frame_start_d;
            update_done_q <= update_done_d;
        end
    end

    assign o_segments    = segments_q;
    assign o_digits      = digits_q;
    assign o_frame_start = frame_start_q;
    assign o_update_done = update_done_q;

endmodule

// File: tb/tb_rtc_seg_scan_mux.sv
// Testbench for rtc_seg_scan_mux with 4 digits, 8-cycle slots and a
// 2-cycle blank window. Frames are 32 cycles, a multiple of the 16-step
// PWM. After reset or re-enable, pwm therefore equals (frame position mod 16)
// at every position.

module tb_rtc_seg_scan_mux;

    localparam int ND  = 4;
    localparam int CPD = 8;
    localparam int BL  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [31:0] seg_data = 32'h0;
    logic [3:0]  mask = 4'h0;
    logic [3:0]  bright = 4'hF;
    logic [7:0]  o_segments;
    logic [3:0]  o_digits;
    logic        o_frame_start;
    logic        o_update_done;

    int errors = 0;
    int checks = 0;

    rtc_seg_scan_mux #(
        .NUM_DIGITS       (ND),
        .CYCLES_PER_DIGIT (CPD),
        .BLANK_CYCLES     (BL),
        .DIGIT_ACTIVE_LOW (1'b1),
        .SEG_OFF          (8'hFF)
    ) dut (
        .i_sys_clk     (clk),
        .i_reset_n     (rst_n),
        .i_enable      (en),
        .i_seg_data    (seg_data),
        .i_blank_mask  (mask),
        .i_load        (load),
        .i_bright      (bright),
        .o_segments    (o_segments),
        .o_digits      (o_digits),
        .o_frame_start (o_frame_start),
        .o_update_done (o_update_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  bright;
        logic [31:0] seg_a;
        logic [3:0]  mask_a;
        int          pos_a;     // frame position at which load A is driven, -1 = none
        logic [31:0] seg_b;
        logic [3:0]  mask_b;
        int          pos_b;
        logic [31:0] exp_seg;   // active data expected in the following frame
        logic [3:0]  exp_mask;
        logic        exp_done;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output expected for frame position p (0..31) given active data.
    task automatic chk_pos(input string tag, input int p, input logic [3:0] br,
                           input logic [3:0] m, input logic [31:0] codes);
        int         k;
        int         c;
        bit         lit;
        logic [3:0] one_hot;
        logic [3:0] exp_dig;
        logic [7:0] exp_seg;
        k       = p / CPD;
        c       = p % CPD;
        lit     = (c >= BL) && ((p % 16) <= int'(br)) && !m[k];
        one_hot = 4'b0001 << k;
        exp_dig = lit ? ~one_hot : 4'b1111;
        exp_seg = lit ? codes[8*k +: 8] : 8'hFF;
        check($sformatf("%s_dig_p%0d", tag, p), o_digits, exp_dig);
        check($sformatf("%s_seg_p%0d", tag, p), o_segments, exp_seg);
        check($sformatf("%s_fs_p%0d", tag, p), o_frame_start, (p == 0));
    endtask

    task automatic chk_off(input string tag);
        check({tag, "_dig"}, o_digits, 4'b1111);
        check({tag, "_seg"}, o_segments, 8'hFF);
        check({tag, "_fs"}, o_frame_start, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_seg;
        logic [3:0]  prev_mask;
        int          n;
        int          lit_cnt;

        vecs[0] = '{"scan",     4'd15, 32'h04030201, 4'b0000, 0,  32'h0, 4'h0, -1, 32'h04030201, 4'b0000, 1'b1};
        vecs[1] = '{"tear",     4'd15, 32'hA3A2A1A0, 4'b0000, 9,  32'h0, 4'h0, -1, 32'hA3A2A1A0, 4'b0000, 1'b1};
        vecs[2] = '{"load_end", 4'd15, 32'h5D5C5B5A, 4'b0000, 30, 32'h0, 4'h0, -1, 32'h5D5C5B5A, 4'b0000, 1'b1};
        vecs[3] = '{"double",   4'd15, 32'h11111111, 4'b0000, 3,  32'h99887766, 4'b0000, 20, 32'h99887766, 4'b0000, 1'b1};
        vecs[4] = '{"mask",     4'd15, 32'hC3C2C1C0, 4'b0100, 5,  32'h0, 4'h0, -1, 32'hC3C2C1C0, 4'b0100, 1'b1};
        vecs[5] = '{"mask_hold",4'd15, 32'h0, 4'h0, -1, 32'h0, 4'h0, -1, 32'hC3C2C1C0, 4'b0100, 1'b0};
        vecs[6] = '{"bright3",  4'd3,  32'h0, 4'h0, -1, 32'h0, 4'h0, -1, 32'hC3C2C1C0, 4'b0100, 1'b0};
        vecs[7] = '{"bright9",  4'd9,  32'hD3D2D1D0, 4'b0000, 14, 32'h0, 4'h0, -1, 32'hD3D2D1D0, 4'b0000, 1'b1};
        vecs[8] = '{"hold15",   4'd15, 32'h0, 4'h0, -1, 32'h0, 4'h0, -1, 32'hD3D2D1D0, 4'b0000, 1'b0};

        // Reset held 3 clocks.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_off("reset");
            check("reset_ud", o_update_done, 1'b0);
        end

        // Release: pos0 blank with frame_start, pos1 blank, pos2 first lit.
        rst_n = 1'b1;
        tick();
        chk_pos("release", 0, 4'd15, 4'b0000, 32'hFFFFFFFF);
        tick();
        chk_pos("release", 1, 4'd15, 4'b0000, 32'hFFFFFFFF);
        tick();
        chk_pos("first_lit", 2, 4'd15, 4'b0000, 32'hFFFFFFFF);

        n = 0;
        do begin
            tick();
            n++;
        end while (!o_frame_start && n < 64);
        check("sync_fs", o_frame_start, 1'b1);
        check("sync_period", n, 30);

        // Each iteration checks one frame of the previous data while loading new data.
        prev_seg  = 32'hFFFFFFFF;
        prev_mask = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            bright = vecs[i].bright;
            for (int p = 0; p < 32; p++) begin
                load = 1'b0;
                if (p == vecs[i].pos_a) begin
                    seg_data = vecs[i].seg_a;
                    mask     = vecs[i].mask_a;
                    load     = 1'b1;
                end
                if (p == vecs[i].pos_b) begin
                    seg_data = vecs[i].seg_b;
                    mask     = vecs[i].mask_b;
                    load     = 1'b1;
                end
                tick();
                if (p < 31) begin
                    chk_pos(vecs[i].name, p + 1, vecs[i].bright, prev_mask, prev_seg);
                    check({vecs[i].name, "_ud_mid"}, o_update_done, 1'b0);
                end else begin
                    chk_pos(vecs[i].name, 0, vecs[i].bright, vecs[i].exp_mask, vecs[i].exp_seg);
                    check({vecs[i].name, "_ud"}, o_update_done, vecs[i].exp_done);
                end
            end
            load      = 1'b0;
            prev_seg  = vecs[i].exp_seg;
            prev_mask = vecs[i].exp_mask;
        end

        // Duty at bright=3 over 64 frames. pwm is phase-locked to the frame, so
        // only slot cycles 2..3 of slots 0 and 2 fall in pwm 0..3: 4 lit per frame.
        bright  = 4'd3;
        lit_cnt = 0;
        for (int t = 0; t < 2048; t++) begin
            tick();
            if (o_digits != 4'b1111) lit_cnt++;
        end
        check("duty_bright3", lit_cnt, 256);
        check("duty_end_fs", o_frame_start, 1'b1);

        // Enable drop mid digit 1, load while disabled, then re-enable.
        bright = 4'd15;
        repeat (12) tick();
        en = 1'b0;
        tick();
        chk_off("dis_next");
        seg_data = 32'hE3E2E1E0;
        mask     = 4'b0000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk_off("dis_load");
        for (int t = 0; t < 3; t++) begin
            tick();
            chk_off("dis_hold");
            check("dis_ud", o_update_done, 1'b0);
        end
        en = 1'b1;
        tick();
        chk_pos("reen", 0, 4'd15, 4'b0000, 32'hD3D2D1D0);
        check("reen_ud", o_update_done, 1'b0);
        for (int p = 1; p < 32; p++) begin
            tick();
            chk_pos("reen", p, 4'd15, 4'b0000, 32'hD3D2D1D0);
        end
        tick();
        chk_pos("reen_commit", 0, 4'd15, 4'b0000, 32'hE3E2E1E0);
        check("reen_commit_ud", o_update_done, 1'b1);
        for (int p = 1; p < 32; p++) begin
            tick();
            chk_pos("reen_new", p, 4'd15, 4'b0000, 32'hE3E2E1E0);
        end
        tick();

        // Reset with a pending load: the load is lost and active data returns to SEG_OFF.
        seg_data = 32'hF3F2F1F0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick();
            chk_off("rst_mid");
            check("rst_mid_ud", o_update_done, 1'b0);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 64; t++) begin
            tick();
            chk_pos("post_rst", t % 32, 4'd15, 4'b0000, 32'hFFFFFFFF);
            check("post_rst_ud", o_update_done, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
